// File: rtl/reg_alu_sequencer_pkg.sv
// Shared definitions for the register/ALU sequencer.
//   op_e    : ALU op codes as presented on the 3-bit op input (7 is reserved)
//   state_e : sequencer FSM states
//   reg_aw  : register address width for a given register count
package reg_alu_sequencer_pkg;

  typedef enum logic [2:0] {
    OpAdd  = 3'd0,
    OpSub  = 3'd1,
    OpAnd  = 3'd2,
    OpOr   = 3'd3,
    OpShl  = 3'd4,
    OpShr  = 3'd5,
    OpMul  = 3'd6,
    OpRsvd = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StTy,
    StTz,
    StWlo,
    StWhi
  } state_e;

  // At least one address bit so a 1-bit port always exists.
  function automatic int unsigned reg_aw(input int unsigned num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/reg_alu_sequencer_if.sv
// Control/debug bundle between the external control unit and the sequencer.
//   master : control unit side (drives start/op/ra/rb/rc, preload and debug-read select)
//   slave  : sequencer side (drives busy/done/err, rd_data, hi, lo, bus_out)
interface reg_alu_sequencer_if
  import reg_alu_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16
);

  localparam int unsigned RegAw = reg_aw(NUM_REGS);

  logic              start;
  logic [2:0]        op;
  logic [RegAw-1:0]  ra;
  logic [RegAw-1:0]  rb;
  logic [RegAw-1:0]  rc;
  logic              busy;
  logic              done;
  logic              err;
  logic              ld_en;
  logic [RegAw-1:0]  ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [RegAw-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] bus_out;

  modport master (
    output start, op, ra, rb, rc, ld_en, ld_addr, ld_data, rd_addr,
    input  busy, done, err, rd_data, hi, lo, bus_out
  );

  modport slave (
    input  start, op, ra, rb, rc, ld_en, ld_addr, ld_data, rd_addr,
    output busy, done, err, rd_data, hi, lo, bus_out
  );

endinterface

// File: rtl/reg_alu_sequencer_alu.sv
// Combinational ALU for the sequencer.
//   y_i      : operand A (Y register)
//   b_i      : operand B (bus value, i.e. Rc)
//   op_i     : operation
//   result_o : 2*DATA_W result; upper half is zero except for MUL
module reg_alu_sequencer_alu
  import reg_alu_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0]   y_i,
  input  logic [DATA_W-1:0]   b_i,
  input  op_e                 op_i,
  output logic [2*DATA_W-1:0] result_o
);

  localparam logic [DATA_W-1:0] ShLimit = DATA_W'(DATA_W);

  logic [DATA_W-1:0] lo_res;
  logic              shift_oob;

  always_comb begin
    // Shift amount is the whole Rc value, not just its low bits.
    shift_oob = (b_i >= ShLimit);
    lo_res    = '0;
    result_o  = '0;
    unique case (op_i)
      OpAdd:   lo_res = y_i + b_i;
      OpSub:   lo_res = y_i - b_i;
      OpAnd:   lo_res = y_i & b_i;
      OpOr:    lo_res = y_i | b_i;
      OpShl:   lo_res = shift_oob ? '0 : (y_i << b_i);
      OpShr:   lo_res = shift_oob ? '0 : (y_i >> b_i);
      default: lo_res = '0;
    endcase
    if (op_i == OpMul) begin
      result_o = {{DATA_W{1'b0}}, y_i} * {{DATA_W{1'b0}}, b_i};
    end else begin
      result_o = {{DATA_W{1'b0}}, lo_res};
    end
  end

endmodule

// File: rtl/reg_alu_sequencer.sv
// Register-file datapath with a single shared bus, sequenced by an internal FSM.
// One register-register op per start/done handshake: Rb->Y, Rc->ALU->Z, Z->Ra (or LO/HI for MUL).
//   clk  : rising-edge clock
//   clr  : asynchronous active-low reset
//   ctl  : slave side of reg_alu_sequencer_if (handshake, preload, debug read, HI/LO, bus)
module reg_alu_sequencer
  import reg_alu_sequencer_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter bit          R0_ZERO  = 1'b0
) (
  input logic                  clk,
  input logic                  clr,
  reg_alu_sequencer_if.slave   ctl
);

  localparam int unsigned RegAw = reg_aw(NUM_REGS);

  state_e              state_q, state_d;
  op_e                 op_q;
  logic [RegAw-1:0]    ra_q, rb_q, rc_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   y_q, hi_q, lo_q;
  logic [2*DATA_W-1:0] z_q;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   bus;
  logic [DATA_W-1:0]   rb_val, rc_val;
  logic [2*DATA_W-1:0] alu_res;
  logic                accept;
  logic                wb_en;
  logic                ld_ok;

  // Non-power-of-two register counts leave unused addresses; those read 0 and ignore writes.
  function automatic logic in_range(input logic [RegAw-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  // R0 is never written when R0_ZERO is set and resets to 0, so plain reads return 0 for it.
  function automatic logic writable(input logic [RegAw-1:0] a);
    return in_range(a) && !(R0_ZERO && (a == '0));
  endfunction

  assign rb_val = in_range(rb_q) ? regs_q[rb_q] : '0;
  assign rc_val = in_range(rc_q) ? regs_q[rc_q] : '0;

  assign accept = (state_q == StIdle) && ctl.start;
  assign wb_en  = (state_q == StWlo) && (op_q != OpMul) && (op_q != OpRsvd) && writable(ra_q);
  // Preload only while idle, so it can never collide with a writeback.
  assign ld_ok  = ctl.ld_en && (state_q == StIdle) && writable(ctl.ld_addr);

  // Shared bus source per state.
  always_comb begin
    bus = '0;
    unique case (state_q)
      StTy:    bus = rb_val;
      StTz:    bus = rc_val;
      StWlo:   bus = z_q[DATA_W-1:0];
      StWhi:   bus = z_q[2*DATA_W-1:DATA_W];
      default: bus = '0;
    endcase
  end

  reg_alu_sequencer_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .y_i      (y_q),
    .b_i      (bus),
    .op_i     (op_q),
    .result_o (alu_res)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ctl.start) begin
          state_d = StTy;
        end
      end
      StTy: state_d = StTz;
      StTz: state_d = StWlo;
      StWlo: begin
        if (op_q == OpMul) begin
          state_d = StWhi;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = (op_q == OpRsvd);
        end
      end
      StWhi: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
      op_q    <= OpAdd;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      y_q     <= '0;
      z_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (accept) begin
        op_q <= op_e'(ctl.op);
        ra_q <= ctl.ra;
        rb_q <= ctl.rb;
        rc_q <= ctl.rc;
      end
      if (state_q == StTy) begin
        y_q <= bus;
      end
      // Reserved op leaves Z untouched.
      if ((state_q == StTz) && (op_q != OpRsvd)) begin
        z_q <= alu_res;
      end
      if ((state_q == StWlo) && (op_q == OpMul)) begin
        lo_q <= bus;
      end
      if (state_q == StWhi) begin
        hi_q <= bus;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en) begin
      regs_q[ra_q] <= bus;
    end else if (ld_ok) begin
      regs_q[ctl.ld_addr] <= ctl.ld_data;
    end
  end

  assign ctl.busy    = (state_q != StIdle);
  assign ctl.done    = done_q;
  assign ctl.err     = err_q;
  assign ctl.rd_data = in_range(ctl.rd_addr) ? regs_q[ctl.rd_addr] : '0;
  assign ctl.hi      = hi_q;
  assign ctl.lo      = lo_q;
  assign ctl.bus_out = bus;

endmodule

// File: tb/tb_reg_alu_sequencer.sv
module tb_reg_alu_sequencer;
  import reg_alu_sequencer_pkg::*;

  localparam int unsigned DataW   = 32;
  localparam int unsigned NumRegs = 16;

  logic clk = 1'b0;
  logic clr = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_alu_sequencer_if #(.DATA_W(DataW), .NUM_REGS(NumRegs)) dif ();

  reg_alu_sequencer #(
    .DATA_W   (DataW),
    .NUM_REGS (NumRegs),
    .R0_ZERO  (1'b1)
  ) dut (
    .clk (clk),
    .clr (clr),
    .ctl (dif)
  );

  typedef struct {
    logic [3:0]  ra;
    logic [31:0] val;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
    int          done_cyc;
    string       name;
  } exp_t;

  typedef enum {CkBusy, CkReg, CkHi, CkLo, CkBus, CkTimeout} ck_e;

  typedef struct {
    ck_e         kind;
    logic [3:0]  addr;
    logic [31:0] val;
    string       name;
  } chk_t;

  exp_t exp_q[$];
  chk_t chk_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: owns rd_addr and all comparisons.
  initial begin : monitor
    exp_t e;
    chk_t c;
    forever begin
      @(negedge clk);
      if (clr) begin
        if (dif.done) begin
          if (exp_q.size() == 0) begin
            cmp("unexpected_done", 32'(dif.done), 32'd0);
          end else begin
            e = exp_q.pop_front();
            dif.rd_addr = e.ra;
            #1;
            cmp({e.name, "_lat"}, 32'(cyc), 32'(e.done_cyc));
            cmp({e.name, "_err"}, 32'(dif.err), 32'(e.err));
            cmp({e.name, "_reg"}, dif.rd_data, e.val);
            cmp({e.name, "_hi"}, dif.hi, e.hi);
            cmp({e.name, "_lo"}, dif.lo, e.lo);
          end
        end else if (chk_q.size() != 0) begin
          c = chk_q.pop_front();
          dif.rd_addr = c.addr;
          #1;
          case (c.kind)
            CkBusy: cmp(c.name, 32'(dif.busy), c.val);
            CkReg:  cmp(c.name, dif.rd_data, c.val);
            CkHi:   cmp(c.name, dif.hi, c.val);
            CkLo:   cmp(c.name, dif.lo, c.val);
            CkBus:  cmp(c.name, dif.bus_out, c.val);
            default: begin
              total++;
              bad++;
              $display("FAIL %s: actual=pending required=empty", c.name);
            end
          endcase
        end
      end
    end
  end

  task automatic check(input ck_e k, input logic [3:0] a, input logic [31:0] v, input string n);
    chk_t c;
    c.kind = k;
    c.addr = a;
    c.val  = v;
    c.name = n;
    chk_q.push_back(c);
  endtask

  task automatic drain();
    int n = 0;
    while ((chk_q.size() != 0 || exp_q.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (chk_q.size() != 0 || exp_q.size() != 0) begin
      exp_q.delete();
      chk_q.delete();
      check(CkTimeout, 4'd0, 32'd0, "drain_timeout");
      repeat (3) @(negedge clk);
    end
    @(negedge clk);
    #2;
  endtask

  task automatic load(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    dif.ld_en   = 1'b1;
    dif.ld_addr = a;
    dif.ld_data = d;
    @(negedge clk);
    dif.ld_en   = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] rc, input logic [31:0] val, input logic [31:0] hi,
                       input logic [31:0] lo, input logic err, input string name);
    exp_t e;
    int   k;
    @(negedge clk);
    dif.start = 1'b1;
    dif.op    = op;
    dif.ra    = ra;
    dif.rb    = rb;
    dif.rc    = rc;
    @(posedge clk);
    #1;
    k         = cyc;
    dif.start = 1'b0;
    e.ra       = ra;
    e.val      = val;
    e.hi       = hi;
    e.lo       = lo;
    e.err      = err;
    e.done_cyc = k + ((op == 3'd6) ? 4 : 3);
    e.name     = name;
    exp_q.push_back(e);
    drain();
  endtask

  function automatic exp_t mk(input logic [3:0] ra, input logic [31:0] val, input int dc,
                              input string name);
    exp_t e;
    e.ra       = ra;
    e.val      = val;
    e.hi       = 32'h2;
    e.lo       = 32'h0;
    e.err      = 1'b0;
    e.done_cyc = dc;
    e.name     = name;
    return e;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int k;
    dif.start   = 1'b0;
    dif.op      = 3'd0;
    dif.ra      = '0;
    dif.rb      = '0;
    dif.rc      = '0;
    dif.ld_en   = 1'b0;
    dif.ld_addr = '0;
    dif.ld_data = '0;
    repeat (3) @(negedge clk);
    clr = 1'b1;

    check(CkBusy, 4'd0, 32'd0, "rst_busy");
    check(CkBus,  4'd0, 32'd0, "rst_bus");
    check(CkHi,   4'd0, 32'd0, "rst_hi");
    check(CkLo,   4'd0, 32'd0, "rst_lo");
    drain();

    // Reset mid-op: no write, no done.
    load(4'd1, 32'd5);
    check(CkReg, 4'd1, 32'd5, "ld_r1");
    drain();
    @(negedge clk);
    dif.start = 1'b1;
    dif.op    = 3'd0;
    dif.ra    = 4'd1;
    dif.rb    = 4'd1;
    dif.rc    = 4'd1;
    @(posedge clk);
    #1 dif.start = 1'b0;
    @(posedge clk);
    #3 clr = 1'b0;
    repeat (2) @(posedge clk);
    #2 clr = 1'b1;
    check(CkBusy, 4'd0, 32'd0, "midrst_busy");
    check(CkReg,  4'd1, 32'd0, "midrst_r1");
    check(CkHi,   4'd0, 32'd0, "midrst_hi");
    check(CkLo,   4'd0, 32'd0, "midrst_lo");
    check(CkBus,  4'd0, 32'd0, "midrst_bus");
    repeat (8) @(negedge clk);
    drain();

    load(4'd2, 32'hFFFF_FFFF);
    load(4'd3, 32'd2);
    issue(3'd0, 4'd1, 4'd2, 4'd3, 32'h0000_0001, 32'h0, 32'h0, 1'b0, "add");

    load(4'd2, 32'h8000_0000);
    load(4'd3, 32'd4);
    issue(3'd6, 4'd1, 4'd2, 4'd3, 32'h0000_0001, 32'h2, 32'h0, 1'b0, "mul");
    issue(3'd1, 4'd8, 4'd2, 4'd3, 32'h7FFF_FFFC, 32'h2, 32'h0, 1'b0, "sub");

    load(4'd9,  32'hF0F0_1234);
    load(4'd10, 32'h0FF0_FF00);
    issue(3'd2, 4'd11, 4'd9, 4'd10, 32'h00F0_1200, 32'h2, 32'h0, 1'b0, "and");
    issue(3'd3, 4'd12, 4'd9, 4'd10, 32'hFFF0_FF34, 32'h2, 32'h0, 1'b0, "or");

    load(4'd4, 32'd3);
    issue(3'd4, 4'd4, 4'd4, 4'd4, 32'h0000_0018, 32'h2, 32'h0, 1'b0, "shl_alias");
    load(4'd5, 32'd40);
    load(4'd6, 32'hDEAD_BEEF);
    issue(3'd5, 4'd6, 4'd4, 4'd5, 32'h0000_0000, 32'h2, 32'h0, 1'b0, "shr_big");
    load(4'd13, 32'd1);
    load(4'd14, 32'd31);
    issue(3'd4, 4'd15, 4'd13, 4'd14, 32'h8000_0000, 32'h2, 32'h0, 1'b0, "shl31");

    // R0 hardwired to zero in this build.
    issue(3'd0, 4'd0, 4'd2, 4'd3, 32'h0, 32'h2, 32'h0, 1'b0, "add_r0");
    load(4'd0, 32'd7);
    check(CkReg, 4'd0, 32'd0, "ld_r0");
    drain();
    issue(3'd7, 4'd9, 4'd2, 4'd3, 32'hF0F0_1234, 32'h2, 32'h0, 1'b1, "rsvd");

    // start held 10 edges: accepted at k, k+4, k+8; ld while busy dropped.
    load(4'd6, 32'd1);
    load(4'd7, 32'd2);
    @(negedge clk);
    dif.start = 1'b1;
    dif.op    = 3'd0;
    dif.ra    = 4'd6;
    dif.rb    = 4'd6;
    dif.rc    = 4'd7;
    @(posedge clk);
    #1;
    k = cyc;
    exp_q.push_back(mk(4'd6, 32'd3, k + 3, "bb0"));
    exp_q.push_back(mk(4'd6, 32'd5, k + 7, "bb1"));
    exp_q.push_back(mk(4'd6, 32'd7, k + 11, "bb2"));
    dif.ld_en   = 1'b1;
    dif.ld_addr = 4'd7;
    dif.ld_data = 32'd100;
    @(posedge clk);
    #1 dif.ld_en = 1'b0;
    repeat (8) @(posedge clk);
    #1 dif.start = 1'b0;
    drain();
    check(CkReg,  4'd7, 32'd2, "ld_busy_dropped");
    check(CkBusy, 4'd0, 32'd0, "bb_idle");
    repeat (4) @(negedge clk);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
